outport_fifo: RTL
=================

OUTPORT_FIFO -- requirements
Module: outport_fifo

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- OutPort_in  in  1  write strobe from the datapath; captures Bus_Data at the edge.
- Bus_Data  in  32  datapath bus value (the out-instruction operand).
- out_ready  in  1  external device is ready to accept the head word.
- ovf_clr  in  1  synchronous clear of the sticky overflow flag.
- Outport_Data_Out  out  32  head word; 32'h0 when empty.
- out_valid  out  1  head word is valid (FIFO not empty).
- full  out  1  count == 4.
- empty  out  1  count == 0.
- count  out  3  occupancy, 0..4.
- ovf  out  1  sticky flag; set when a write is dropped.

Function
REQ-002 The module SHALL implement a 4-entry × 32-bit first-word-fall-through FIFO using 2-bit read and write pointers that wrap from 3 to 0.
REQ-003 Push: the module SHALL accept a push on an edge where OutPort_in=1 and (full=0 or a pop occurs on the same edge), storing Bus_Data at the write pointer and incrementing it.
REQ-004 Pop: the module SHALL pop on an edge where out_valid=1 and out_ready=1, incrementing the read pointer.
REQ-005 out_valid SHALL equal !empty, and Outport_Data_Out SHALL equal the entry at the read pointer, or 32'h0 when empty.
REQ-006 Latency: a word pushed into an empty FIFO at edge N SHALL appear on Outport_Data_Out with out_valid=1 immediately after edge N, with no bubble.
REQ-007 count SHALL change as follows: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
REQ-008 When full and a push and pop occur on the same edge, the module SHALL accept both, leave count at 4, and set no overflow.
REQ-009 When empty with OutPort_in=1 and out_ready=1, the module SHALL perform only the push (no pop, since out_valid=0).
REQ-010 When full with OutPort_in=1 and no pop, the module SHALL drop the write, leave the FIFO contents unchanged, and set ovf=1 at that edge.
REQ-011 ovf SHALL remain set until ovf_clr=1 at an edge; if ovf_clr and a new overflow occur on the same edge, ovf SHALL remain 1 (set wins).
REQ-012 Outport_Data_Out SHALL be held stable while out_valid=1 and out_ready=0.
REQ-013 The module SHALL hold a 1-bit state machine on the external side: IDLE (empty) and PRESENT (word offered). Transitions:
- IDLE→PRESENT on a push.
- PRESENT→IDLE on a pop with count==1 and no push.
- Otherwise the state holds.
- state==PRESENT SHALL be equivalent to out_valid.

Reset
REQ-014 While clr=1, the module SHALL asynchronously force both pointers to 0, count=0, ovf=0 and state=IDLE, giving outputs empty=1, full=0, out_valid=0, Outport_Data_Out=32'h0.
REQ-015 Storage array contents need not be reset, but SHALL never be visible while empty.
REQ-016 A reset asserted mid-transfer SHALL discard all queued words; the first push after clr deasserts SHALL behave as a push into an empty FIFO.

Configuration
REQ-017 The macro OUTPORT_SEVENSEG_EN SHALL control a seven-segment display feature.
- Defined: add outputs hex_lo[6:0] and hex_hi[6:0], active-low segments gfedcba.
- These outputs SHALL register the low and high nibbles of bits [7:0] of each popped word at the pop edge.
- Reset value SHALL be 7'h7F (blank), and the outputs SHALL hold until the next pop.
- Undefined: these ports and their registers SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- Reset, then one cycle with OutPort_in=1 and Bus_Data=32'hFCAE1020 -> after that edge out_valid=1, Outport_Data_Out=32'hFCAE1020, count=1.
- 5 consecutive pushes (32'h1..32'h5) with out_ready=0 -> count=4, full=1, ovf=1; then out_ready=1 -> pops 1,2,3,4 in order, and 5 is never seen.
- Full FIFO, push 32'hA5 with out_ready=1 on the same edge -> count stays 4, ovf=0, and 32'hA5 emerges fourth.
- Write pointer wraps: 6 pushes interleaved with pops -> output order matches input order and count never exceeds 4.
- clr pulsed with count=3 -> immediately empty=1 and Outport_Data_Out=32'h0; next push 32'h7 -> out_valid=1 with 32'h7.
- With OUTPORT_SEVENSEG_EN defined, pop 32'h000000A3 -> hex_hi=7'h08 ("A") and hex_lo=7'h30 ("3") after the pop edge.

Source files
------------

// File: rtl/outport_fifo_if.sv
// Handshake/bus bundle for the output-port FIFO.
// OUTPORT_SEVENSEG_EN adds the hex_lo/hex_hi seven-segment outputs.
interface outport_fifo_if;
  logic        OutPort_in;
  logic [31:0] Bus_Data;
  logic        out_ready;
  logic        ovf_clr;
  logic [31:0] Outport_Data_Out;
  logic        out_valid;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        ovf;
`ifdef OUTPORT_SEVENSEG_EN
  logic [6:0]  hex_lo;
  logic [6:0]  hex_hi;
`endif

  modport master (
    output OutPort_in, Bus_Data, out_ready, ovf_clr,
    input  Outport_Data_Out, out_valid, full, empty, count, ovf
`ifdef OUTPORT_SEVENSEG_EN
    , input hex_lo, hex_hi
`endif
  );

  modport slave (
    input  OutPort_in, Bus_Data, out_ready, ovf_clr,
    output Outport_Data_Out, out_valid, full, empty, count, ovf
`ifdef OUTPORT_SEVENSEG_EN
    , output hex_lo, hex_hi
`endif
  );
endinterface

// File: rtl/outport_fifo.sv
// 4 x 32 first-word-fall-through output-port FIFO with sticky overflow flag.
// OUTPORT_SEVENSEG_EN enables seven-segment display of each popped byte.
module outport_fifo (
  input  logic          clk,
  input  logic          clr,
  outport_fifo_if.slave bus
);

  typedef enum logic {IDLE, PRESENT} state_t;

  logic [31:0] r_mem [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic        r_ovf;
  state_t      r_state;
  state_t      w_state_nxt;

  logic w_full;
  logic w_valid;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == 3'd4);
  assign w_valid = (r_state == PRESENT);
  assign w_pop   = w_valid & bus.out_ready;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign w_push  = bus.OutPort_in & (~w_full | w_pop);
  assign w_drop  = bus.OutPort_in & w_full & ~w_pop;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_push) w_state_nxt = PRESENT;
      PRESENT: if (w_pop && (r_count == 3'd1) && !w_push) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.Bus_Data;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      // Set has priority over the synchronous clear.
      if (w_drop)           r_ovf <= 1'b1;
      else if (bus.ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign bus.out_valid        = w_valid;
  assign bus.Outport_Data_Out = w_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.full             = w_full;
  assign bus.empty            = (r_count == 3'd0);
  assign bus.count            = r_count;
  assign bus.ovf              = r_ovf;

`ifdef OUTPORT_SEVENSEG_EN
  logic [6:0] r_hex_lo;
  logic [6:0] r_hex_hi;

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_hex_lo <= '1;
      r_hex_hi <= '1;
    end else if (w_pop) begin
      r_hex_lo <= seg7(r_mem[r_rd_ptr][3:0]);
      r_hex_hi <= seg7(r_mem[r_rd_ptr][7:4]);
    end
  end

  assign bus.hex_lo = r_hex_lo;
  assign bus.hex_hi = r_hex_hi;
`endif

endmodule
